// File: rtl/pipeexe_stage.sv
// Execute stage of the five-stage MIPS pipeline: ID/EX register plus ALU.
// ealu/ern are combinational from the latched bundle so decode can forward them.
module pipeexe_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        dwreg,
    input  logic        dm2reg,
    input  logic        dwmem,
    input  logic        daluimm,
    input  logic        dshift,
    input  logic        djal,
    input  logic [3:0]  daluc,
    input  logic [31:0] da,
    input  logic [31:0] db,
    input  logic [31:0] dimm,
    input  logic [4:0]  drn,
    input  logic [31:0] dpc4,
    output logic        ewreg,
    output logic        em2reg,
    output logic        ewmem,
    output logic [4:0]  ern,
    output logic [31:0] ealu,
    output logic [31:0] eb
);

    logic        wreg_q;
    logic        m2reg_q;
    logic        wmem_q;
    logic        aluimm_q;
    logic        shift_q;
    logic        jal_q;
    logic [3:0]  aluc_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] imm_q;
    logic [4:0]  rn_q;
    logic [31:0] pc4_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wreg_q   <= 1'b0;
            m2reg_q  <= 1'b0;
            wmem_q   <= 1'b0;
            aluimm_q <= 1'b0;
            shift_q  <= 1'b0;
            jal_q    <= 1'b0;
            aluc_q   <= 4'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            imm_q    <= 32'd0;
            rn_q     <= 5'd0;
            pc4_q    <= 32'd0;
        end else begin
            wreg_q   <= dwreg;
            m2reg_q  <= dm2reg;
            wmem_q   <= dwmem;
            aluimm_q <= daluimm;
            shift_q  <= dshift;
            jal_q    <= djal;
            aluc_q   <= daluc;
            a_q      <= da;
            b_q      <= db;
            imm_q    <= dimm;
            rn_q     <= drn;
            pc4_q    <= dpc4;
        end
    end

    // Decode already places the sa field in operand A, so the shift flag has no use here.
    logic unused_shift;
    assign unused_shift = shift_q;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  shamt;
    logic [31:0] alu_result;

    assign alu_a = a_q;
    assign alu_b = aluimm_q ? imm_q : b_q;
    assign shamt = alu_a[4:0];

    always_comb begin
        alu_result = 32'd0;
        unique casez (aluc_q)
            4'b?000: alu_result = alu_a + alu_b;
            4'b?100: alu_result = alu_a - alu_b;
            4'b?001: alu_result = alu_a & alu_b;
            4'b?101: alu_result = alu_a | alu_b;
            4'b?010: alu_result = alu_a ^ alu_b;
            4'b?110: alu_result = {alu_b[15:0], 16'h0000};
            4'b0011: alu_result = alu_b << shamt;
            4'b0111: alu_result = alu_b >> shamt;
            4'b1111: alu_result = $unsigned($signed(alu_b) >>> shamt);
            4'b1011: alu_result = 32'd0;
            default: alu_result = 32'd0;
        endcase
    end

    // jal writes its return address (PC+8) into $31.
    assign ealu   = jal_q ? (pc4_q + 32'd4) : alu_result;
    assign ern    = jal_q ? 5'd31 : rn_q;
    assign ewreg  = wreg_q;
    assign em2reg = m2reg_q;
    assign ewmem  = wmem_q;
    assign eb     = b_q;

endmodule

// File: doc/pipeexe_stage.md
# pipeexe_stage

Execute stage of the five-stage pipelined MIPS core. It contains the ID/EX pipeline register and the ALU. It captures the decode-stage control bundle and operands on every rising clock edge and computes the ALU result, destination register and memory-control outputs. Its outputs feed the EX/MEM register and go back to the decode stage as the EX-stage forwarding and load-use hazard sources.

## Interface
Parameters:
- none. Data width is fixed at 32 bits and register index width at 5 bits.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- dwreg  in  1  instruction writes the register file
- dm2reg  in  1  register writeback data comes from memory (load)
- dwmem  in  1  instruction writes data memory (store)
- daluimm  in  1  ALU operand B is the immediate
- dshift  in  1  shift instruction; da already carries the zero-extended sa field
- djal  in  1  jump-and-link
- daluc  in  4  ALU operation code
- da  in  32  operand A after forwarding
- db  in  32  operand B after forwarding; also the store data
- dimm  in  32  sign- or zero-extended immediate
- drn  in  5  destination register index
- dpc4  in  32  PC+4 of the instruction in decode
- ewreg  out  1  latched dwreg
- em2reg  out  1  latched dm2reg
- ewmem  out  1  latched dwmem
- ern  out  5  destination index; forced to 31 when the latched jal is 1
- ealu  out  32  ALU result, or PC+8 for jal
- eb  out  32  latched db, passed on as the store data

## Operation
- ID/EX register: on each rising edge, latch every d* input into its e* counterpart. There is no enable and no hold.
  - Stall bubbles arrive as all-zero control signals from decode.
  - Control squashing is done in decode, not here.
- Operand selection: A = ea; B = ealuimm ? eimm : eb.
- ALU, decoded from ealuc ("x" = don't-care):
  - x000: ADD, A+B, modulo 2^32
  - x100: SUB, A−B, modulo 2^32
  - x001: AND
  - x101: OR
  - x010: XOR
  - x110: LUI, {B[15:0], 16'h0}
  - 0011: SLL, B << A[4:0]
  - 0111: SRL, B >> A[4:0] with zero fill
  - 1111: SRA, B >>> A[4:0] with sign fill
  - 1011: produces 0
- Arithmetic rules:
  - No overflow detection or trap.
  - Only A[4:0] is used as the shift amount; higher bits of A are ignored.
- Output muxing:
  - ealu = ejal ? (epc4 + 4) : alu_result
  - ern = ejal ? 5'd31 : ern_latched
- ewreg, em2reg, ewmem and eb are direct register outputs.

## Timing
- Latency: one cycle. Inputs presented before edge N appear on the e* outputs after edge N.
- ealu and ern are combinational from the latched state and settle within the same cycle. Decode can therefore forward ealu and compare ern before edge N+1.
- Reset is synchronous. When reset=1 at a rising edge, all latched fields are cleared to 0. Resulting outputs:
  - ewreg = em2reg = ewmem = 0
  - ern = 0, eb = 0
  - ealu = 0 (ADD of 0 and 0)
- Reset takes priority over capture on the same edge. An instruction in flight at reset is discarded; no write enable survives.
- Between reset assertion and the first edge, outputs keep their previous values.
- A bubble (all controls 0) produces ewreg = ewmem = 0. ealu and ern are don't-care in that case but deterministic.
- No back-pressure: the block accepts a new bundle every cycle.

## Test plan
- ADD: da=32'h7FFFFFFF, db=1, daluc=0000, dwreg=1, drn=5; one edge → ealu=32'h80000000, ern=5, ewreg=1.
- SUB / immediate select: daluimm=1, dimm=32'hFFFFFFFF, da=3, daluc=0100 → ealu=4. Repeat with daluimm=0, db=3 → ealu=0.
- Shifts: dshift=1, da=32'd4 (sa), db=32'h80000000.
  - SRA (1111) → ealu=32'hF8000000
  - SRL (0111) → ealu=32'h08000000
  - SLL (0011) with da=32'h24 → ealu=0, since only A[4:0]=4 is used and bit 31 shifts out.
- LUI and JAL:
  - dimm=32'h00001234, daluimm=1, daluc=0110 → ealu=32'h12340000.
  - djal=1, dpc4=32'h00400010, drn=0 → ealu=32'h00400014, ern=31.
- Bubble and store: all controls 0 → ewreg=ewmem=0. Next, dwmem=1 with db=32'hDEADBEEF → ewmem=1, eb=32'hDEADBEEF, ewreg=0.
- Reset mid-stream: load a bundle with dwreg=1, dm2reg=1, then assert reset for one edge while presenting dwreg=1 → all outputs 0. Deassert reset → the next bundle latches normally.
